// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generator feeding a DEPTH-entry in-order {pc, ir} buffer toward decode.
// Optional feature macro RVGA_FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and raise misaligned_o.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_v_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_v_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_v_o,
    input  logic        decode_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic        misaligned_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Discard counter is wider than DEPTH: back-to-back redirects with a slow memory can stack drops.
    localparam int DW = PW + 3;

    logic [31:0]    pc_q, pc_d;
    logic [31:0]    ent_pc_q [DEPTH];
    logic [31:0]    ent_pc_d [DEPTH];
    logic [31:0]    ent_ir_q [DEPTH];
    logic [31:0]    ent_ir_d [DEPTH];
    logic [DEPTH-1:0] ent_filled_q, ent_filled_d;
    logic [PW-1:0]  head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
    logic [CW-1:0]  count_q, count_d, pend_q, pend_d;
    logic [DW-1:0]  drop_q, drop_d;

    logic           halt;
    logic           deq;
    logic           req_fire;
    logic           resp_keep;
    logic [CW-1:0]  occ_after;
    logic [31:0]    redir_tgt;

`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
    logic halt_q, halt_d;
    assign halt         = halt_q;
    assign misaligned_o = halt_q;
`else
    assign halt         = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    assign redir_tgt       = redirect_pc_i & 32'hFFFF_FFFC;
    assign fetch_v_o       = !rst_i && !redirect_v_i && ent_filled_q[head_q];
    assign pc_o            = ent_pc_q[head_q];
    assign ir_o            = ent_ir_q[head_q];
    assign deq             = fetch_v_o && decode_ready_i;
    // A dequeue this cycle frees its slot for a request in the same cycle.
    assign occ_after       = count_q - CW'(deq);
    assign imem_req_v_o    = !rst_i && !redirect_v_i && !halt && (occ_after < CW'(DEPTH));
    assign imem_req_addr_o = pc_q & 32'hFFFF_FFFC;
    assign req_fire        = imem_req_v_o && imem_req_ready_i;
    assign resp_keep       = imem_resp_v_i && (drop_q == '0);

    always_comb begin
        pc_d         = pc_q;
        ent_pc_d     = ent_pc_q;
        ent_ir_d     = ent_ir_q;
        ent_filled_d = ent_filled_q;
        head_d       = head_q;
        alloc_d      = alloc_q;
        fill_d       = fill_q;
        count_d      = count_q;
        pend_d       = pend_q;
        drop_d       = drop_q;
`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
        halt_d       = halt_q;
`endif
        if (redirect_v_i) begin
            pc_d         = redir_tgt;
            ent_filled_d = '0;
            head_d       = '0;
            alloc_d      = '0;
            fill_d       = '0;
            count_d      = '0;
            pend_d       = '0;
            // Every unfilled entry still has a response coming; a response this cycle consumes one.
            drop_d       = drop_q + DW'(pend_q) - DW'(imem_resp_v_i);
`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
            halt_d       = (redirect_pc_i[1:0] != 2'b00);
`endif
        end else begin
            if (req_fire) begin
                ent_pc_d[alloc_q]     = pc_q;
                ent_filled_d[alloc_q] = 1'b0;
                alloc_d               = alloc_q + PW'(1);
                pc_d                  = pc_q + 32'd4;
            end
            if (imem_resp_v_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - DW'(1);
                end else begin
                    ent_ir_d[fill_q]     = imem_resp_data_i;
                    ent_filled_d[fill_q] = 1'b1;
                    fill_d               = fill_q + PW'(1);
                end
            end
            if (deq) begin
                ent_filled_d[head_q] = 1'b0;
                head_d               = head_q + PW'(1);
            end
            count_d = count_q + CW'(req_fire) - CW'(deq);
            pend_d  = pend_q + CW'(req_fire) - CW'(resp_keep);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i] <= '0;
                ent_ir_q[i] <= '0;
            end
            ent_filled_q <= '0;
            head_q       <= '0;
            alloc_q      <= '0;
            fill_q       <= '0;
            count_q      <= '0;
            pend_q       <= '0;
            drop_q       <= '0;
`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
            halt_q       <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            ent_pc_q     <= ent_pc_d;
            ent_ir_q     <= ent_ir_d;
            ent_filled_q <= ent_filled_d;
            head_q       <= head_d;
            alloc_q      <= alloc_d;
            fill_q       <= fill_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
            halt_q       <= halt_d;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random/directed stimulus for fetch_unit with a latency-programmable memory
// and a scoreboard holding the expected in-order {pc, ir} stream.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_v_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_v_i;
    logic [31:0] imem_resp_data_i;
    logic        redirect_v_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_v_o;
    logic        decode_ready_i;
    logic [31:0] pc_o;
    logic [31:0] ir_o;
    logic        misaligned_o;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_v_o(imem_req_v_o), .imem_req_addr_o(imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i), .imem_resp_v_i(imem_resp_v_i),
        .imem_resp_data_i(imem_resp_data_i), .redirect_v_i(redirect_v_i),
        .redirect_pc_i(redirect_pc_i), .fetch_v_o(fetch_v_o),
        .decode_ready_i(decode_ready_i), .pc_o(pc_o), .ir_o(ir_o),
        .misaligned_o(misaligned_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int lat = 1;
    int rdy_pct = 100;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1 ^ (a * 32'd3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // memory model: fixed latency, in-order, random request acceptance
    typedef struct { int due; logic [31:0] addr; } mreq_t;
    mreq_t mq[$];
    initial begin
        mreq_t r;
        logic nv;
        logic [31:0] nd;
        imem_req_ready_i = 1'b0;
        imem_resp_v_i    = 1'b0;
        imem_resp_data_i = '0;
        forever begin
            @(negedge clk_i);
            nv = 1'b0;
            nd = '0;
            if (rst_i) begin
                mq.delete();
            end else begin
                if (imem_req_v_o && imem_req_ready_i) begin
                    r.due  = cyc + lat;
                    r.addr = imem_req_addr_o;
                    mq.push_back(r);
                end
                if (mq.size() > 0 && mq[0].due == cyc + 1) begin
                    nv = 1'b1;
                    nd = mem_fn(mq[0].addr);
                    void'(mq.pop_front());
                end
            end
            @(posedge clk_i);
            #1;
            imem_resp_v_i    = nv;
            imem_resp_data_i = nv ? nd : $urandom;
            imem_req_ready_i = ($urandom_range(99) < rdy_pct);
        end
    end

    // scoreboard: expected stream of delivered {pc, ir}; flushed on redirect
    logic [63:0] exp_q[$];
    logic [31:0] req_pc_m;
    logic        halt_m;
    int          stall;
    initial begin
        logic deq;
        logic exp_rv;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                exp_q.delete();
                req_pc_m = RST_PC;
                halt_m   = 1'b0;
                stall    = 0;
            end else begin
                deq    = fetch_v_o && decode_ready_i;
                exp_rv = !redirect_v_i && !halt_m && ((exp_q.size() - (deq ? 1 : 0)) < DEPTH);
                check1("misaligned_o", misaligned_o, halt_m);
                check1("req_v", imem_req_v_o, exp_rv);
                if (redirect_v_i) check1("fetch_v_during_redirect", fetch_v_o, 1'b0);
                if (fetch_v_o) begin
                    if (exp_q.size() == 0) begin
                        check1("fetch_v_when_empty", fetch_v_o, 1'b0);
                    end else begin
                        check("pc_o", pc_o, exp_q[0][63:32]);
                        check("ir_o", ir_o, exp_q[0][31:0]);
                    end
                end
                if (redirect_v_i) begin
                    exp_q.delete();
                    req_pc_m = redirect_pc_i & 32'hFFFF_FFFC;
`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
                    halt_m = (redirect_pc_i[1:0] != 2'b00);
`else
                    halt_m = 1'b0;
`endif
                end else begin
                    if (deq && exp_q.size() > 0) void'(exp_q.pop_front());
                    if (imem_req_v_o && imem_req_ready_i) begin
                        check("req_addr", imem_req_addr_o, req_pc_m);
                        exp_q.push_back({req_pc_m, mem_fn(req_pc_m)});
                        req_pc_m = req_pc_m + 32'd4;
                    end
                end
                if (!redirect_v_i && exp_q.size() > 0 && !fetch_v_o) stall++;
                else stall = 0;
                if (stall > 30) begin
                    check("fetch_progress_stall", stall, 0);
                    stall = 0;
                end
            end
        end
    end

    // driver tasks
    task automatic reset_dut(input int l);
        lat   = l;
        rst_i = 1'b1;
        redirect_v_i = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk_i);
        check1("rst_req_v", imem_req_v_o, 1'b0);
        check("rst_req_addr", imem_req_addr_o, RST_PC);
        check1("rst_fetch_v", fetch_v_o, 1'b0);
        check("rst_pc_o", pc_o, 32'h0);
        check("rst_ir_o", ir_o, 32'h0);
        check1("rst_misaligned", misaligned_o, 1'b0);
        next_cycle();
        rst_i = 1'b0;
    endtask

    // From a drive point: redirect this cycle, return at the negedge of the following cycle.
    task automatic do_redirect(input logic [31:0] tgt);
        redirect_v_i  = 1'b1;
        redirect_pc_i = tgt;
        @(negedge clk_i);
        check1("redir_fetch_v", fetch_v_o, 1'b0);
        next_cycle();
        redirect_v_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_fetch(input string name, input logic [31:0] p);
        int k = 0;
        @(negedge clk_i);
        while (!fetch_v_o && k < 20) begin
            next_cycle();
            @(negedge clk_i);
            k++;
        end
        check1({name, "_valid"}, fetch_v_o, 1'b1);
        check(name, pc_o, p);
        next_cycle();
    endtask

    initial begin
        int ndeq;
        int nreq;
        logic [31:0] held;
        logic [31:0] tgt;
        rst_i = 1'b1;
        redirect_v_i = 1'b0;
        redirect_pc_i = '0;
        decode_ready_i = 1'b1;

        // reset, first-fetch latency, sustained throughput
        reset_dut(1);
        @(negedge clk_i);
        check1("first_req_v", imem_req_v_o, 1'b1);
        check("first_req_addr", imem_req_addr_o, RST_PC);
        check1("fetch_v_cycle1", fetch_v_o, 1'b0);
        next_cycle(); @(negedge clk_i);
        check1("fetch_v_cycle2", fetch_v_o, 1'b0);
        next_cycle(); @(negedge clk_i);
        check1("fetch_v_cycle3", fetch_v_o, 1'b1);
        check("first_pc", pc_o, RST_PC);
        ndeq = 0;
        repeat (20) begin
            next_cycle(); @(negedge clk_i);
            if (fetch_v_o && decode_ready_i) ndeq++;
        end
        check("throughput", ndeq, 20);

        // decode back-pressure fills the buffer
        next_cycle();
        decode_ready_i = 1'b0;
        @(negedge clk_i);
        held = pc_o;
        for (int i = 1; i < 10; i++) begin
            next_cycle(); @(negedge clk_i);
            check("held_pc", pc_o, held);
        end
        check1("full_req_v", imem_req_v_o, 1'b0);
        check1("full_fetch_v", fetch_v_o, 1'b1);
        next_cycle();
        decode_ready_i = 1'b1;
        repeat (10) next_cycle();

        // L=3 redirect with responses in flight
        reset_dut(3);
        repeat (12) next_cycle();
        do_redirect(32'h0000_0200);
        check1("redir_l3_req_v", imem_req_v_o, 1'b1);
        check("redir_l3_req_addr", imem_req_addr_o, 32'h0000_0200);
        next_cycle();
        wait_fetch("redir_l3_pc", 32'h0000_0200);

        // L=1 redirect coinciding with a response and a would-be dequeue
        reset_dut(1);
        repeat (8) next_cycle();
        do_redirect(32'h0000_0400);
        check("redir_l1_req_addr", imem_req_addr_o, 32'h0000_0400);
        next_cycle();
        wait_fetch("redir_l1_pc", 32'h0000_0400);

        // PC wrap
        repeat (3) next_cycle();
        do_redirect(32'hFFFF_FFF8);
        check("wrap_addr0", imem_req_addr_o, 32'hFFFF_FFF8);
        next_cycle(); @(negedge clk_i);
        check("wrap_addr1", imem_req_addr_o, 32'hFFFF_FFFC);
        next_cycle(); @(negedge clk_i);
        check("wrap_addr2", imem_req_addr_o, 32'h0000_0000);
        next_cycle();
        repeat (6) next_cycle();

        // misaligned redirect
        do_redirect(32'h0000_0202);
`ifdef RVGA_FETCH_MISALIGN_CHECK_EN
        check1("misalign_flag_set", misaligned_o, 1'b1);
        nreq = 0;
        repeat (20) begin
            next_cycle(); @(negedge clk_i);
            if (imem_req_v_o) nreq++;
        end
        check("halt_no_requests", nreq, 0);
        next_cycle();
        do_redirect(32'h0000_0300);
        check1("misalign_flag_clear", misaligned_o, 1'b0);
        check("resume_req_addr", imem_req_addr_o, 32'h0000_0300);
        next_cycle();
        wait_fetch("resume_pc", 32'h0000_0300);
`else
        check1("misalign_flag_tied", misaligned_o, 1'b0);
        check("misalign_forced_addr", imem_req_addr_o, 32'h0000_0200);
        next_cycle();
        wait_fetch("misalign_forced_pc", 32'h0000_0200);
`endif

        // randomized traffic
        for (int r = 0; r < 3; r++) begin
            reset_dut($urandom_range(4, 1));
            rdy_pct = 70;
            for (int k = 0; k < 400; k++) begin
                decode_ready_i = ($urandom_range(99) < 70);
                if ($urandom_range(99) < 4) begin
                    case ($urandom_range(7))
                        0:       tgt = 32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2);
                        1:       tgt = 32'h0000_0800 | 32'($urandom_range(3));
                        default: tgt = 32'h0000_1000 + (32'($urandom_range(255)) << 2);
                    endcase
                    redirect_v_i  = 1'b1;
                    redirect_pc_i = tgt;
                end else begin
                    redirect_v_i = 1'b0;
                end
                next_cycle();
            end
            redirect_v_i   = 1'b0;
            decode_ready_i = 1'b1;
            repeat (40) next_cycle();
            rdy_pct = 100;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
